// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared FSM state encodings for the debouncer and downstream counter FSMs
package btn_debounce_pkg;

  // Encodings are fixed so downstream counter FSMs can decode the same values.
  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_IDLE_HIGH = 2'b11,
    ST_WAIT_LOW  = 2'b10
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser for asynchronous inputs
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Two back-to-back flops give the first stage a full cycle to resolve metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronised, stability-qualified push-button debouncer with rise/fall strobes
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, rise_n, fall_n;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s2)
  );

  // Next state, counter and outputs; strobes default low so each lasts one cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = btn_level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      ST_IDLE_LOW: begin
        if (s2) begin
          state_n = ST_WAIT_HIGH;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!s2) begin
          state_n = ST_IDLE_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_IDLE_HIGH;
          cnt_n   = '0;
          level_n = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_IDLE_HIGH: begin
        if (!s2) begin
          state_n = ST_WAIT_LOW;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (s2) begin
          state_n = ST_IDLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_IDLE_LOW;
          cnt_n   = '0;
          level_n = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM state, stability counter and registered outputs; reset discards any pending acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      btn_level <= level_n;
      btn_rise  <= rise_n;
      btn_fall  <= fall_n;
    end
  end

endmodule
